// File: rtl/layer_sched_if.sv
// rtl/layer_sched_if.sv - layer sequencer handshake, config and DRAM bus bundle
interface layer_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_ENG    = 4
);
  logic                             start;
  logic                             cfg_we;
  logic [2:0]                       cfg_idx;
  logic [$clog2(NUM_ENG)-1:0]       cfg_eng;
  logic [3:0]                       cfg_num;
  logic [NUM_ENG-1:0]               eng_enable;
  logic [NUM_ENG-1:0]               eng_done;
  logic [NUM_ENG*ADDR_WIDTH-1:0]    eng_addr_rd;
  logic [NUM_ENG*ADDR_WIDTH-1:0]    eng_addr_wr;
  logic [NUM_ENG-1:0]               eng_en_rd;
  logic [NUM_ENG-1:0]               eng_en_wr;
  logic [NUM_ENG*DATA_WIDTH-1:0]    eng_wdata;
  logic [ADDR_WIDTH-1:0]            dram_addr_rd;
  logic [ADDR_WIDTH-1:0]            dram_addr_wr;
  logic                             dram_en_rd;
  logic                             dram_en_wr;
  logic [DATA_WIDTH-1:0]            dram_wdata;
  logic                             busy;
  logic                             done;
  logic                             err_timeout;
  logic [2:0]                       cur_layer;
  logic [31:0]                      run_cycles;

  modport slave (
    input  start, cfg_we, cfg_idx, cfg_eng, cfg_num,
           eng_done, eng_addr_rd, eng_addr_wr, eng_en_rd, eng_en_wr, eng_wdata,
    output eng_enable, dram_addr_rd, dram_addr_wr, dram_en_rd, dram_en_wr, dram_wdata,
           busy, done, err_timeout, cur_layer, run_cycles
  );

  modport master (
    output start, cfg_we, cfg_idx, cfg_eng, cfg_num,
           eng_done, eng_addr_rd, eng_addr_wr, eng_en_rd, eng_en_wr, eng_wdata,
    input  eng_enable, dram_addr_rd, dram_addr_wr, dram_en_rd, dram_en_wr, dram_wdata,
           busy, done, err_timeout, cur_layer, run_cycles
  );
endinterface

// File: rtl/layer_sched.sv
// rtl/layer_sched.sv - CNN layer sequencer: launches engines from a layer list and muxes DRAM
module layer_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_ENG    = 4,
  parameter int MAX_LAYERS = 8,
  parameter int TIMEOUT    = 1 << 20
) (
  input  logic            clk,
  input  logic            srst,
  layer_sched_if.slave    bus
);
  localparam int EW  = $clog2(NUM_ENG);
  localparam int LW  = $clog2(MAX_LAYERS);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t            r_state, w_next;
  logic [EW-1:0]     r_list [MAX_LAYERS];
  logic [LW:0]       r_num;
  logic [LW-1:0]     r_cur;
  logic [WDW-1:0]    r_wd;
  logic              r_err;
  logic [31:0]       r_cycles;

  logic [EW-1:0]     w_gnt;
  logic              w_granted;
  logic              w_gnt_done;
  logic              w_wd_exp;
  logic              w_last;
  logic [LW:0]       w_num;

  assign w_gnt      = r_list[r_cur];
  assign w_granted  = (r_state == S_LAUNCH) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_gnt_done = bus.eng_done[w_gnt];
  assign w_wd_exp   = (r_wd == WDW'(TIMEOUT - 1));
  assign w_last     = ({1'b0, r_cur} == r_num - (LW+1)'(1));
  assign w_num      = (bus.cfg_num > (LW+1)'(MAX_LAYERS)) ? (LW+1)'(MAX_LAYERS) : bus.cfg_num;

  always_ff @(posedge clk) begin
    if (srst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // A done from the granted engine wins over a watchdog expiry in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = (bus.cfg_num == '0) ? S_FIN : S_LAUNCH;
      S_LAUNCH: w_next = S_RUN;
      S_RUN: begin
        if (w_gnt_done)    w_next = S_DRAIN;
        else if (w_wd_exp) w_next = S_FIN;
      end
      S_DRAIN:  w_next = w_last ? S_FIN : S_LAUNCH;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < MAX_LAYERS; i++) r_list[i] <= '0;
      r_num    <= '0;
      r_cur    <= '0;
      r_wd     <= '0;
      r_err    <= 1'b0;
      r_cycles <= '0;
    end else begin
      if (r_state == S_IDLE && bus.cfg_we) r_list[bus.cfg_idx] <= bus.cfg_eng;
      if (r_state == S_IDLE && bus.start) begin
        r_num    <= w_num;
        r_cur    <= '0;
        r_err    <= 1'b0;
        r_cycles <= '0;
      end else if (r_state != S_IDLE && r_cycles != '1) begin
        r_cycles <= r_cycles + 32'd1;
      end
      if (r_state == S_LAUNCH) r_wd <= '0;
      if (r_state == S_RUN)    r_wd <= r_wd + WDW'(1);
      if (r_state == S_RUN && !w_gnt_done && w_wd_exp) r_err <= 1'b1;
      if (r_state == S_DRAIN && !w_last) r_cur <= r_cur + LW'(1);
    end
  end

  always_comb begin
    bus.busy         = (r_state != S_IDLE);
    bus.done         = (r_state == S_FIN);
    bus.err_timeout  = r_err;
    bus.cur_layer    = 3'(r_cur);
    bus.run_cycles   = r_cycles;
    bus.eng_enable   = '0;
    bus.dram_addr_rd = '0;
    bus.dram_addr_wr = '0;
    bus.dram_en_rd   = 1'b0;
    bus.dram_en_wr   = 1'b0;
    bus.dram_wdata   = '0;
    if (r_state == S_LAUNCH) bus.eng_enable = NUM_ENG'(1) << w_gnt;
    if (w_granted) begin
      bus.dram_addr_rd = bus.eng_addr_rd[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
      bus.dram_addr_wr = bus.eng_addr_wr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
      bus.dram_en_rd   = bus.eng_en_rd[w_gnt];
      bus.dram_en_wr   = bus.eng_en_wr[w_gnt];
      bus.dram_wdata   = bus.eng_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_layer_sched.sv
// tb/tb_layer_sched.sv - self-checking bench for layer_sched against a layer-list reference model
module tb_layer_sched;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int NE = 4;
  localparam int TO = 24;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  layer_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE)) bus();

  layer_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .MAX_LAYERS(8), .TIMEOUT(TO))
    dut (.clk(clk), .srst(srst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int model_list [8];
  int dly [8];
  logic [AW-1:0] m_ard [NE];
  logic [AW-1:0] m_awr [NE];
  logic [DW-1:0] m_wd  [NE];
  logic [NE-1:0] m_enrd, m_enwr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_eng(input bit force3);
    for (int e = 0; e < NE; e++) begin
      m_ard[e] = AW'($urandom);
      m_awr[e] = AW'($urandom);
      m_wd[e]  = DW'($urandom);
    end
    m_enrd = NE'($urandom);
    m_enwr = NE'($urandom);
    if (force3) begin
      m_enwr[3] = 1'b1;
      m_awr[3]  = 18'h3FFFF;
    end
    for (int e = 0; e < NE; e++) begin
      bus.eng_addr_rd[e*AW +: AW] = m_ard[e];
      bus.eng_addr_wr[e*AW +: AW] = m_awr[e];
      bus.eng_wdata[e*DW +: DW]   = m_wd[e];
    end
    bus.eng_en_rd = m_enrd;
    bus.eng_en_wr = m_enwr;
  endtask

  task automatic chk_dram(input int g, input bit active);
    #1;
    chk("dram_addr_rd", 64'(bus.dram_addr_rd), active ? 64'(m_ard[g]) : 64'd0);
    chk("dram_addr_wr", 64'(bus.dram_addr_wr), active ? 64'(m_awr[g]) : 64'd0);
    chk("dram_wdata",   64'(bus.dram_wdata),   active ? 64'(m_wd[g])  : 64'd0);
    chk("dram_en_rd",   64'(bus.dram_en_rd),   active ? 64'(m_enrd[g]) : 64'd0);
    chk("dram_en_wr",   64'(bus.dram_en_wr),   active ? 64'(m_enwr[g]) : 64'd0);
  endtask

  task automatic cfg_write(input int idx, input int eng);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_eng = 2'(eng);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    model_list[idx] = eng;
  endtask

  // Full run: each layer costs launch + dly + drain cycles, plus one FIN cycle.
  task automatic do_run(input int n_cfg, input bit simul_we);
    int n, g, exp_cycles;
    n = (n_cfg > 8) ? 8 : n_cfg;
    bus.cfg_num = 4'(n_cfg);
    bus.start   = 1'b1;
    if (simul_we) begin
      g = $urandom_range(0, 3);
      bus.cfg_we  = 1'b1;
      bus.cfg_idx = 3'd0;
      bus.cfg_eng = 2'(g);
      model_list[0] = g;
    end
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    exp_cycles = 1;
    for (int i = 0; i < n; i++) begin
      g = model_list[i];
      chk("eng_enable", 64'(bus.eng_enable), 64'(1) << g);
      chk("cur_layer", 64'(bus.cur_layer), 64'(i));
      chk("err_cleared", 64'(bus.err_timeout), 64'd0);
      drive_eng(1'b0);
      chk_dram(g, 1'b1);
      for (int k = 1; k <= dly[i]; k++) begin
        @(negedge clk);
        if (k == 1) chk("enable_pulse_end", 64'(bus.eng_enable), 64'd0);
        bus.start  = (k == 2);
        bus.cfg_we = (k == 2);
        bus.cfg_idx = 3'($urandom);
        bus.cfg_eng = 2'($urandom);
        drive_eng(k == 1);
        chk_dram(g, 1'b1);
        bus.eng_done = (NE'($urandom) & ~(NE'(1) << g)) | ((k == dly[i]) ? (NE'(1) << g) : NE'(0));
      end
      @(negedge clk);
      bus.eng_done = '0;
      bus.start    = 1'b0;
      bus.cfg_we   = 1'b0;
      chk("busy_drain", 64'(bus.busy), 64'd1);
      @(negedge clk);
      exp_cycles += dly[i] + 2;
    end
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("fin_enable", 64'(bus.eng_enable), 64'd0);
    drive_eng(1'b0);
    chk_dram(0, 1'b0);
    @(negedge clk);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("done_low", 64'(bus.done), 64'd0);
    chk("run_cycles", 64'(bus.run_cycles), 64'(exp_cycles));
  endtask

  initial begin
    int g;
    srst = 1'b1;
    bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_eng = '0; bus.cfg_num = '0;
    bus.eng_done = '0;
    drive_eng(1'b0);
    for (int i = 0; i < 8; i++) model_list[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err", 64'(bus.err_timeout), 64'd0);
    chk("rst_cur", 64'(bus.cur_layer), 64'd0);
    chk("rst_cycles", 64'(bus.run_cycles), 64'd0);
    chk("rst_enable", 64'(bus.eng_enable), 64'd0);
    chk_dram(0, 1'b0);
    srst = 1'b0;
    @(negedge clk);

    cfg_write(0, 2); cfg_write(1, 0); cfg_write(2, 1);
    for (int i = 0; i < 8; i++) dly[i] = 20;
    do_run(3, 1'b0);

    do_run(0, 1'b0);

    cfg_write(0, 3);
    bus.cfg_num = 4'd3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("to_enable", 64'(bus.eng_enable), 64'd8);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      bus.eng_done = NE'($urandom) & 4'b0111;
    end
    chk("to_err_before", 64'(bus.err_timeout), 64'd0);
    chk("to_busy_before", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.eng_done = '0;
    chk("to_done", 64'(bus.done), 64'd1);
    chk("to_err", 64'(bus.err_timeout), 64'd1);
    chk("to_no_launch", 64'(bus.eng_enable), 64'd0);
    @(negedge clk);
    chk("to_idle", 64'(bus.busy), 64'd0);
    chk("to_cycles", 64'(bus.run_cycles), 64'(TO + 2));
    chk("to_err_sticky", 64'(bus.err_timeout), 64'd1);
    chk("to_no_relaunch", 64'(bus.eng_enable), 64'd0);

    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 4; w++) cfg_write($urandom_range(0, 7), $urandom_range(0, 3));
      for (int i = 0; i < 8; i++) dly[i] = $urandom_range(1, 12);
      do_run($urandom_range(1, 12), r[0]);
    end

    cfg_write(0, 1); cfg_write(1, 2);
    dly[0] = 5;
    bus.cfg_num = 4'd3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (dly[0] - 1) @(negedge clk);
    bus.eng_done = 4'b0010;
    @(negedge clk);
    bus.eng_done = '0;
    @(negedge clk);
    chk("srst_layer1", 64'(bus.cur_layer), 64'd1);
    chk("srst_launch", 64'(bus.eng_enable), 64'd4);
    repeat (3) @(negedge clk);
    bus.eng_en_rd = '1;
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("srst_busy", 64'(bus.busy), 64'd0);
    chk("srst_en_rd", 64'(bus.dram_en_rd), 64'd0);
    chk("srst_cur", 64'(bus.cur_layer), 64'd0);
    chk("srst_enable", 64'(bus.eng_enable), 64'd0);
    for (int i = 0; i < 8; i++) model_list[i] = 0;
    for (int i = 0; i < 8; i++) dly[i] = $urandom_range(1, 6);
    do_run(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
